// File: rtl/branch_ctrl.sv
// Branch controller: target lookup table, return-address stack and halt latch.
// branch/branch_adr/Halt are combinational from the strobes and the registered state;
// the table, stack, occupancy, error flag and halt latch update on the clock edge.
module branch_ctrl #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned LUT_ENTRIES = 32
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] PC,
    input  logic       op_jmp,
    input  logic       op_bz,
    input  logic       op_bnz,
    input  logic       op_call,
    input  logic       op_ret,
    input  logic       op_halt,
    input  logic       zero,
    input  logic [4:0] tgt_idx,
    input  logic       lut_we,
    input  logic [4:0] lut_waddr,
    input  logic [7:0] lut_wdata,
    output logic       branch,
    output logic [7:0] branch_adr,
    output logic       Halt,
    output logic       stack_err,
    output logic [3:0] depth
);

    localparam int unsigned IdxW     = $clog2(STACK_DEPTH);
    localparam logic [3:0]  DepthMax = 4'(STACK_DEPTH);

    logic [7:0] lut_q   [LUT_ENTRIES];
    logic [7:0] stack_q [STACK_DEPTH];
    logic [3:0] depth_q;
    logic       stack_err_q;
    logic       halt_q;

    logic [3:0]      top_ptr;
    logic [IdxW-1:0] push_idx;
    logic [IdxW-1:0] pop_idx;
    logic [7:0]      ret_adr;
    logic [7:0]      lut_rdata;
    logic            unused_ptr_bits;

    logic do_push;
    logic do_pop;
    logic set_err;
    logic set_halt;

    assign top_ptr         = depth_q - 4'd1;
    assign push_idx        = depth_q[IdxW-1:0];
    assign pop_idx         = top_ptr[IdxW-1:0];
    assign unused_ptr_bits = ^top_ptr[3:IdxW];
    // Return address wraps naturally in 8 bits (PC=255 pushes 0).
    assign ret_adr         = PC + 8'd1;
    // Reads see the pre-edge contents, so a same-cycle write returns the old value.
    assign lut_rdata       = lut_q[tgt_idx];

    assign stack_err = stack_err_q;
    assign depth     = depth_q;

    // Priority decode: halt > ret > call > jmp > bz > bnz; reset forces outputs low.
    always_comb begin
        branch     = 1'b0;
        branch_adr = 8'h00;
        Halt       = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_err    = 1'b0;
        set_halt   = 1'b0;
        if (Reset) begin
            Halt = 1'b0;
        end else if (halt_q) begin
            Halt = 1'b1;
        end else if (op_halt) begin
            Halt     = 1'b1;
            set_halt = 1'b1;
        end else if (op_ret) begin
            if (depth_q != 4'd0) begin
                branch     = 1'b1;
                branch_adr = stack_q[pop_idx];
                do_pop     = 1'b1;
            end else begin
                set_err  = 1'b1;
                set_halt = 1'b1;
            end
        end else if (op_call) begin
            if (depth_q < DepthMax) begin
                branch     = 1'b1;
                branch_adr = lut_rdata;
                do_push    = 1'b1;
            end else begin
                set_err  = 1'b1;
                set_halt = 1'b1;
            end
        end else if (op_jmp) begin
            branch     = 1'b1;
            branch_adr = lut_rdata;
        end else if (op_bz) begin
            branch     = zero;
            branch_adr = lut_rdata;
        end else if (op_bnz) begin
            branch     = ~zero;
            branch_adr = lut_rdata;
        end
    end

    // State update: table writes always apply; stack/flags only move when not halted.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(LUT_ENTRIES); i++) begin
                lut_q[i] <= 8'h00;
            end
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= 8'h00;
            end
            depth_q     <= 4'd0;
            stack_err_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            if (lut_we) begin
                lut_q[lut_waddr] <= lut_wdata;
            end
            if (do_push) begin
                stack_q[push_idx] <= ret_adr;
                depth_q           <= depth_q + 4'd1;
            end else if (do_pop) begin
                depth_q <= depth_q - 4'd1;
            end
            if (set_err) begin
                stack_err_q <= 1'b1;
            end
            if (set_halt) begin
                halt_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: the driver computes expected outputs from a
// queue-based model and pushes them; a negedge monitor pops and compares.
module tb_branch_ctrl;

    localparam int SD = 4;

    localparam logic [5:0] OP_HALT = 6'b100000;
    localparam logic [5:0] OP_RET  = 6'b010000;
    localparam logic [5:0] OP_CALL = 6'b001000;
    localparam logic [5:0] OP_JMP  = 6'b000100;
    localparam logic [5:0] OP_BZ   = 6'b000010;
    localparam logic [5:0] OP_BNZ  = 6'b000001;
    localparam logic [5:0] OP_NONE = 6'b000000;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] PC = 8'h00;
    logic       op_jmp = 1'b0, op_bz = 1'b0, op_bnz = 1'b0;
    logic       op_call = 1'b0, op_ret = 1'b0, op_halt = 1'b0;
    logic       zero = 1'b0;
    logic [4:0] tgt_idx = 5'd0;
    logic       lut_we = 1'b0;
    logic [4:0] lut_waddr = 5'd0;
    logic [7:0] lut_wdata = 8'h00;
    logic       branch;
    logic [7:0] branch_adr;
    logic       Halt;
    logic       stack_err;
    logic [3:0] depth;

    branch_ctrl #(.STACK_DEPTH(SD), .LUT_ENTRIES(32)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PC         (PC),
        .op_jmp     (op_jmp),
        .op_bz      (op_bz),
        .op_bnz     (op_bnz),
        .op_call    (op_call),
        .op_ret     (op_ret),
        .op_halt    (op_halt),
        .zero       (zero),
        .tgt_idx    (tgt_idx),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .branch     (branch),
        .branch_adr (branch_adr),
        .Halt       (Halt),
        .stack_err  (stack_err),
        .depth      (depth)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       br;
        logic [7:0] adr;
        logic       adr_chk;
        logic       halt;
        logic       err;
        logic [3:0] dep;
        string      tag;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [7:0] ret_m[$];
    logic [7:0] lut_m[32];
    bit         halted_m;
    bit         err_m;

    int checks = 0;
    int errors = 0;

    function automatic void cmp(string name, string tag, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
        end
    endfunction

    // Monitor: compare DUT outputs against the oldest expectation each negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("branch", e.tag, {7'd0, branch}, {7'd0, e.br});
                cmp("halt", e.tag, {7'd0, Halt}, {7'd0, e.halt});
                cmp("stack_err", e.tag, {7'd0, stack_err}, {7'd0, e.err});
                cmp("depth", e.tag, {4'd0, depth}, {4'd0, e.dep});
                if (e.adr_chk) cmp("branch_adr", e.tag, branch_adr, e.adr);
            end
        end
    end

    task automatic model_clear();
        ret_m.delete();
        for (int i = 0; i < 32; i++) lut_m[i] = 8'h00;
        halted_m = 1'b0;
        err_m    = 1'b0;
    endtask

    // Reset asserted part-way through a cycle; outputs must clear with no edge.
    task automatic do_reset(string tag);
        exp_t e;
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        {op_halt, op_ret, op_call, op_jmp, op_bz, op_bnz} = 6'($urandom);
        lut_we = 1'b0;
        model_clear();
        e = '{br: 1'b0, adr: 8'h00, adr_chk: 1'b1, halt: 1'b0, err: 1'b0, dep: 4'd0, tag: tag};
        sb.push_back(e);
    endtask

    task automatic cyc(string tag, logic [5:0] ops, logic [7:0] pc, logic z, logic [4:0] tgt,
                       logic we, logic [4:0] wa, logic [7:0] wd);
        exp_t e;
        bit   push = 0, pop = 0, fault = 0;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        {op_halt, op_ret, op_call, op_jmp, op_bz, op_bnz} = ops;
        PC = pc; zero = z; tgt_idx = tgt;
        lut_we = we; lut_waddr = wa; lut_wdata = wd;

        e.tag = tag;
        e.br = 1'b0; e.adr = 8'h00; e.adr_chk = 1'b0;
        e.err = err_m; e.dep = 4'(ret_m.size());
        e.halt = halted_m || ops[5];
        if (!halted_m && !ops[5]) begin
            if (ops[4]) begin
                if (ret_m.size() > 0) begin
                    e.br = 1'b1; e.adr = ret_m[$]; e.adr_chk = 1'b1; pop = 1;
                end else fault = 1;
            end else if (ops[3]) begin
                if (ret_m.size() < SD) begin
                    e.br = 1'b1; e.adr = lut_m[tgt]; e.adr_chk = 1'b1; push = 1;
                end else fault = 1;
            end else if (ops[2]) begin
                e.br = 1'b1; e.adr = lut_m[tgt]; e.adr_chk = 1'b1;
            end else if (ops[1]) begin
                e.br = z; e.adr = lut_m[tgt]; e.adr_chk = 1'b1;
            end else if (ops[0]) begin
                e.br = !z; e.adr = lut_m[tgt]; e.adr_chk = 1'b1;
            end else begin
                e.adr_chk = 1'b1;
            end
        end
        sb.push_back(e);

        // Effects at the coming edge
        if (we) lut_m[wa] = wd;
        if (push) ret_m.push_back(8'((int'(pc) + 1) % 256));
        if (pop) void'(ret_m.pop_back());
        if (fault) begin err_m = 1'b1; halted_m = 1'b1; end
        if (!halted_m && ops[5]) halted_m = 1'b1;
    endtask

    task automatic idle(string tag);
        cyc(tag, OP_NONE, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
    endtask

    task automatic wr(string tag, logic [4:0] a, logic [7:0] d);
        cyc(tag, OP_NONE, 8'h00, 1'b0, 5'd0, 1'b1, a, d);
    endtask

    initial begin
        logic [5:0] ops;
        model_clear();

        do_reset("reset0");
        idle("post_reset");

        // Call/return round trip
        wr("wr_lut3", 5'd3, 8'h40);
        cyc("call", OP_CALL, 8'h10, 1'b0, 5'd3, 1'b0, 5'd0, 8'h00);
        cyc("ret", OP_RET, 8'h20, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
        idle("after_ret");

        // Conditional branches
        wr("wr_lut7", 5'd7, 8'h22);
        cyc("bz_z1", OP_BZ, 8'h00, 1'b1, 5'd7, 1'b0, 5'd0, 8'h00);
        cyc("bz_z0", OP_BZ, 8'h00, 1'b0, 5'd7, 1'b0, 5'd0, 8'h00);
        cyc("bnz_z1", OP_BNZ, 8'h00, 1'b1, 5'd7, 1'b0, 5'd0, 8'h00);
        cyc("bnz_z0", OP_BNZ, 8'h00, 1'b0, 5'd7, 1'b0, 5'd0, 8'h00);

        // Same-cycle read/write of one index returns the old value
        cyc("rw_same", OP_JMP, 8'h00, 1'b0, 5'd7, 1'b1, 5'd7, 8'h99);
        cyc("rw_new", OP_JMP, 8'h00, 1'b0, 5'd7, 1'b0, 5'd0, 8'h00);

        // Wrap of pushed return address, and call beating jmp
        cyc("call_ff", OP_CALL, 8'hFF, 1'b0, 5'd3, 1'b0, 5'd0, 8'h00);
        cyc("ret_wrap", OP_RET, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
        cyc("jmp_call", OP_JMP | OP_CALL, 8'h30, 1'b0, 5'd7, 1'b0, 5'd0, 8'h00);
        idle("prio_depth");

        // Overflow
        do_reset("reset_ovf");
        for (int i = 0; i < SD; i++) cyc("fill", OP_CALL, 8'(i), 1'b0, 5'd1, 1'b0, 5'd0, 8'h00);
        cyc("call_full", OP_CALL, 8'h50, 1'b0, 5'd1, 1'b0, 5'd0, 8'h00);
        idle("ovf_state");
        cyc("jmp_halted", OP_JMP, 8'h00, 1'b0, 5'd1, 1'b1, 5'd2, 8'h77);
        cyc("jmp_halted2", OP_JMP | OP_BNZ, 8'h00, 1'b0, 5'd2, 1'b0, 5'd0, 8'h00);

        // Underflow
        do_reset("reset_unf");
        cyc("ret_empty", OP_RET, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
        idle("unf_state");

        // Halted at depth 3, then async reset clears everything
        do_reset("reset_h3");
        wr("wr_lut9", 5'd9, 8'h5A);
        for (int i = 0; i < 3; i++) cyc("call3", OP_CALL, 8'h40, 1'b0, 5'd9, 1'b0, 5'd0, 8'h00);
        cyc("halt_op", OP_HALT | OP_RET, 8'h00, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
        idle("halted_d3");
        do_reset("reset_async");
        cyc("lut_cleared", OP_JMP, 8'h00, 1'b0, 5'd9, 1'b0, 5'd0, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ((halted_m && $urandom_range(0, 3) == 0) || $urandom_range(0, 63) == 0) begin
                do_reset("rnd_reset");
            end else begin
                ops = 6'($urandom) & 6'($urandom);
                if ($urandom_range(0, 15) != 0) ops[5] = 1'b0;
                cyc("rnd", ops, 8'($urandom), 1'($urandom), 5'($urandom),
                    ($urandom_range(0, 2) == 0), 5'($urandom), 8'($urandom));
            end
        end
        idle("drain");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CLK);
        @(negedge CLK);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
